exe_alu_sequencer: RTL and testbench
====================================

// Module: exe_alu_sequencer
// PURPOSE
// - Execute-stage initiator for the 64-bit combinational ALU (ports num1, num2, control[1:0], out).
// - Accepts decoded Y86 instructions over a valid/ready handshake.
// - Selects the ALU operands and the ALU control code, then registers valE.
// - Owns the condition-code register (ZF, SF, OF) and evaluates jXX/cmovXX conditions.
// - Sits between the decode stage and the memory stage. Latency is 1 cycle.
// PARAMETERS
// - W         64      datapath width; the ISA fixes it at 64 (legal range 8..64)
// - CC_RST    3'b100  reset value of {ZF,SF,OF}
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - in_valid   in   1   decode offers an instruction
// - in_ready   out  1   this block accepts an instruction this cycle
// - in_icode   in   4   Y86 icode
// - in_ifun    in   4   Y86 ifun
// - in_valA    in   W   register operand A
// - in_valB    in   W   register operand B
// - in_valC    in   W   immediate or displacement
// - alu_num1   out  W   ALU num1 (combinational from in_*)
// - alu_num2   out  W   ALU num2 (combinational from in_*)
// - alu_ctrl   out  2   ALU control: 00 add, 01 sub, 10 and, 11 xor
// - alu_out    in   W   ALU result
// - out_valid  out  1   registered result is valid
// - out_ready  in   1   memory stage takes the result
// - out_icode  out  4   icode passed through
// - out_valE   out  W   registered ALU result
// - out_valA   out  W   valA passed through, for memory writes
// - out_cnd    out  1   condition result for jXX/cmovXX; 0 for all other icodes
// - out_err    out  1   illegal icode, or OPq with ifun>3
// - cc         out  3   current {ZF,SF,OF}
// BEHAVIOUR
// - Reset (async): state=EMPTY, out_*=0, cc=CC_RST.
// - in_ready = (state==EMPTY) | (state==FULL & out_ready & out_icode!=0).
// - accept = in_valid & in_ready. On accept, all out_* load on the clock edge and state goes to FULL.
// - FULL & out_ready & ~accept -> EMPTY. If out_icode==0 (halt), go to HALTED instead.
// - HALTED: in_ready=0, out_valid=0. Only rst leaves this state.
// - Simultaneous drain and accept: FULL is kept and the new data replaces the old; there is no bubble.
// - out_valid=1 in FULL only. While FULL & ~out_ready, every out_* is held stable.
// - Operand select:
//   - num2 = valA for icode 2 and 6; valC for 3, 4, 5; -8 for 8 and A; +8 for 9 and B; 0 otherwise.
//   - num1 = valB for icode 4, 5, 6, 8, 9, A, B; 0 otherwise.
// - alu_ctrl = ifun[1:0] when icode==6, else 00.
// - Subtraction is num1-num2 = valB-valA, per the Y86 convention.
// - CC updates only on accept of icode 6 with ifun<=3:
//   - ZF = (res==0); SF = res[W-1].
//   - add: OF = (a[W-1]==b[W-1]) & (res[W-1]!=b[W-1]).
//   - sub: OF = (valB[W-1]!=valA[W-1]) & (res[W-1]!=valB[W-1]).
//   - and/xor: OF = 0.
// - The ALU overflow output is ignored.
// - Condition (icode 2 or 7) uses cc before this instruction's edge. With ifun:
//   - 0 -> 1; 1 -> (SF^OF)|ZF; 2 -> SF^OF; 3 -> ZF; 4 -> ~ZF; 5 -> ~(SF^OF); 6 -> ~(SF^OF)&~ZF; 7..F -> 0.
// - Illegal instruction (icode>B, or icode 6 with ifun>3): out_err=1, out_valE=0, cc unchanged. It still flows through.
// - Reset mid-operation: the in-flight result is dropped. No output reaches memory after rst rises.
// CONFIGURATION
// - EXE_PERF_CNT_EN defined: adds outputs perf_insn[31:0] and perf_stall[31:0], both reset to 0.
//   - perf_insn += 1 on each accept.
//   - perf_stall += 1 each cycle with FULL & ~out_ready.
//   - Both wrap from 2^32-1 to 0.
// - EXE_PERF_CNT_EN undefined: these ports and the counter logic do not exist.
// TESTING
// 1. rst, then OPq addq valA=1 valB=0x7FFF_FFFF_FFFF_FFFF with ALU model -> alu_ctrl=00; next cycle valE=0x8000..0, cc=3'b011.
// 2. OPq subq valA=5 valB=5 -> valE=0, cc=100. Then jXX ifun=3 -> out_cnd=1. Then jXX ifun=4 -> out_cnd=0.
// 3. pushq valB=0x100 -> num1=0x100, num2=-8, valE=0xF8, cc unchanged. Same for popq -> valE=0x108.
// 4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable. Release -> drain and accept in the same cycle, no bubble.
// 5. halt, then in_valid=1 with irmovq -> halt drains once, then HALTED: in_ready=0 until rst.
// 6. OPq ifun=7 -> out_err=1, valE=0, cc unchanged. With EXE_PERF_CNT_EN: 5 accepts, 3 stalled cycles -> perf_insn=5, perf_stall=3.

Source files
------------

// File: rtl/exe_alu_sequencer.sv
// Y86 execute stage: drives the external ALU, registers valE and owns {ZF,SF,OF}.
// Optional EXE_PERF_CNT_EN adds perf_insn / perf_stall counters.
module exe_alu_sequencer #(
    parameter int unsigned W      = 64,
    parameter logic [2:0]  CC_RST = 3'b100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    output logic [W-1:0] alu_num1,
    output logic [W-1:0] alu_num2,
    output logic [1:0]   alu_ctrl,
    input  logic [W-1:0] alu_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_icode,
    output logic [W-1:0] out_valE,
    output logic [W-1:0] out_valA,
    output logic         out_cnd,
    output logic         out_err,
    output logic [2:0]   cc
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [31:0]  perf_insn,
    output logic [31:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HALTED} state_t;

    typedef struct packed {
        logic [3:0]   icode;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic         cnd;
        logic         err;
    } rsp_t;

    localparam logic [W-1:0] C_PLUS8  = W'(8);
    localparam logic [W-1:0] C_MINUS8 = ~C_PLUS8 + 1'b1;

    state_t      r_state, w_state_nxt;
    rsp_t        r_rsp, w_rsp;
    logic [2:0]  r_cc;
    logic        w_accept;
    logic        w_illegal;
    logic        w_cc_upd;
    logic        w_zf, w_sf, w_of;
    logic        w_cond;
    logic        w_sxo;

    // Operand routing follows the Y86 SEQ/PIPE aluA/aluB selection.
    always_comb begin
        alu_num2 = '0;
        case (in_icode)
            4'h2, 4'h6:       alu_num2 = in_valA;
            4'h3, 4'h4, 4'h5: alu_num2 = in_valC;
            4'h8, 4'hA:       alu_num2 = C_MINUS8;
            4'h9, 4'hB:       alu_num2 = C_PLUS8;
            default:          alu_num2 = '0;
        endcase
    end

    always_comb begin
        alu_num1 = '0;
        case (in_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_num1 = in_valB;
            default:                                  alu_num1 = '0;
        endcase
    end

    assign alu_ctrl  = (in_icode == 4'h6) ? in_ifun[1:0] : 2'b00;
    assign w_illegal = (in_icode > 4'hB) | ((in_icode == 4'h6) & (in_ifun > 4'd3));
    assign w_cc_upd  = w_accept & (in_icode == 4'h6) & (in_ifun <= 4'd3);

    assign w_zf = (alu_out == '0);
    assign w_sf = alu_out[W-1];

    always_comb begin
        w_of = 1'b0;
        case (in_ifun[1:0])
            2'b00:   w_of = (in_valA[W-1] == in_valB[W-1]) & (alu_out[W-1] != in_valB[W-1]);
            2'b01:   w_of = (in_valB[W-1] != in_valA[W-1]) & (alu_out[W-1] != in_valB[W-1]);
            default: w_of = 1'b0;
        endcase
    end

    // Conditions see the flags as they stand before this instruction's edge.
    assign w_sxo = r_cc[1] ^ r_cc[0];

    always_comb begin
        w_cond = 1'b0;
        case (in_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = w_sxo | r_cc[2];
            4'h2:    w_cond = w_sxo;
            4'h3:    w_cond = r_cc[2];
            4'h4:    w_cond = ~r_cc[2];
            4'h5:    w_cond = ~w_sxo;
            4'h6:    w_cond = ~w_sxo & ~r_cc[2];
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_rsp       = '0;
        w_rsp.icode = in_icode;
        w_rsp.valE  = w_illegal ? '0 : alu_out;
        w_rsp.valA  = in_valA;
        w_rsp.cnd   = ((in_icode == 4'h2) | (in_icode == 4'h7)) & w_cond;
        w_rsp.err   = w_illegal;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_EMPTY: in_ready = 1'b1;
            S_FULL:  in_ready = out_ready & (r_rsp.icode != 4'h0);
            default: in_ready = 1'b0;
        endcase
        w_accept = in_valid & in_ready;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL: begin
                // A drained halt parks the stage until reset.
                if (w_accept)
                    w_state_nxt = S_FULL;
                else if (out_ready)
                    w_state_nxt = (r_rsp.icode == 4'h0) ? S_HALTED : S_EMPTY;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_rsp   <= '0;
            r_cc    <= CC_RST;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_rsp <= w_rsp;
            if (w_cc_upd) r_cc  <= {w_zf, w_sf, w_of};
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_icode = r_rsp.icode;
    assign out_valE  = r_rsp.valE;
    assign out_valA  = r_rsp.valA;
    assign out_cnd   = r_rsp.cnd;
    assign out_err   = r_rsp.err;
    assign cc        = r_cc;

`ifdef EXE_PERF_CNT_EN
    logic [31:0] r_perf_insn, r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_insn  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) r_perf_insn <= r_perf_insn + 32'd1;
            if ((r_state == S_FULL) & ~out_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_insn  = r_perf_insn;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_exe_alu_sequencer.sv
// Bench for exe_alu_sequencer: vector table through a scoreboard, plus stall, halt and reset sequences.
module tb_exe_alu_sequencer;
    localparam int W = 64;
    localparam logic [63:0] M8  = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   in_icode, in_ifun, out_icode;
    logic [W-1:0] in_valA, in_valB, in_valC;
    logic [W-1:0] alu_num1, alu_num2, alu_out, out_valE, out_valA;
    logic [1:0]   alu_ctrl;
    logic         out_cnd, out_err;
    logic [2:0]   cc;
`ifdef EXE_PERF_CNT_EN
    logic [31:0]  perf_insn, perf_stall;
`endif

    always #5 clk = ~clk;

    // Reference 64-bit ALU sitting outside the DUT.
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            2'b00: alu_out = alu_num1 + alu_num2;
            2'b01: alu_out = alu_num1 - alu_num2;
            2'b10: alu_out = alu_num1 & alu_num2;
            2'b11: alu_out = alu_num1 ^ alu_num2;
            default: alu_out = '0;
        endcase
    end

    exe_alu_sequencer #(.W(W), .CC_RST(3'b100)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_valE(out_valE), .out_valA(out_valA),
        .out_cnd(out_cnd), .out_err(out_err), .cc(cc)
`ifdef EXE_PERF_CNT_EN
        , .perf_insn(perf_insn), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [3:0]  icode, ifun;
        logic [63:0] a, b, c, n1, n2;
        logic [1:0]  ctrl;
        logic [63:0] e;
        logic        cnd, err;
        logic [2:0]  cc;
    } vec_t;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] e, a;
        logic        cnd, err;
        logic [2:0]  cc;
    } exp_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t sb[$];
    exp_t cur_exp;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [63:0] n1, input logic [63:0] n2, input logic [1:0] ctrl,
                                input logic [63:0] e, input logic cnd, input logic err,
                                input logic [2:0] ccv);
        vec_t v;
        v.icode = icode; v.ifun = ifun; v.a = a; v.b = b; v.c = c;
        v.n1 = n1; v.n2 = n2; v.ctrl = ctrl; v.e = e;
        v.cnd = cnd; v.err = err; v.cc = ccv;
        return v;
    endfunction

    // Scoreboard: pop on a taken output, push on a taken input.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL sb_underflow: unexpected output icode=%0h at %0t", out_icode, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_icode", 64'(out_icode), 64'(e.icode));
                    chk("out_valE",  out_valE, e.e);
                    chk("out_valA",  out_valA, e.a);
                    chk("out_cnd",   64'(out_cnd), 64'(e.cnd));
                    chk("out_err",   64'(out_err), 64'(e.err));
                    chk("cc",        64'(cc), 64'(e.cc));
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic apply(input vec_t v);
        in_valid = 1'b1;
        in_icode = v.icode; in_ifun = v.ifun;
        in_valA = v.a; in_valB = v.b; in_valC = v.c;
        cur_exp.icode = v.icode; cur_exp.e = v.e; cur_exp.a = v.a;
        cur_exp.cnd = v.cnd; cur_exp.err = v.err; cur_exp.cc = v.cc;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // icode ifun valA valB valC | num1 num2 ctrl valE cnd err cc_after
        tbl.push_back(mk(4'h6, 4'h0, 64'h1, MAX, 64'h0, MAX, 64'h1, 2'd0, MSB, 0, 0, 3'b011));
        tbl.push_back(mk(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 64'h5, 64'h5, 2'd1, 64'h0, 0, 0, 3'b100));
        tbl.push_back(mk(4'h7, 4'h3, 64'h0, 64'h0, 64'h1234, 64'h0, 64'h0, 2'd0, 64'h0, 1, 0, 3'b100));
        tbl.push_back(mk(4'h7, 4'h4, 64'h0, 64'h0, 64'h1234, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b100));
        tbl.push_back(mk(4'hA, 4'h0, 64'h11, 64'h100, 64'h0, 64'h100, M8, 2'd0, 64'hF8, 0, 0, 3'b100));
        tbl.push_back(mk(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 64'h100, 64'h8, 2'd0, 64'h108, 0, 0, 3'b100));
        tbl.push_back(mk(4'h2, 4'h2, 64'h55, 64'h0, 64'h0, 64'h0, 64'h55, 2'd0, 64'h55, 0, 0, 3'b100));
        tbl.push_back(mk(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, 64'h0, 64'h0FF0, 64'hF0F0, 2'd2, 64'h00F0, 0, 0, 3'b000));
        tbl.push_back(mk(4'h2, 4'h5, 64'h77, 64'h0, 64'h0, 64'h0, 64'h77, 2'd0, 64'h77, 1, 0, 3'b000));
        tbl.push_back(mk(4'h6, 4'h3, MSB, 64'h0, 64'h0, 64'h0, MSB, 2'd3, MSB, 0, 0, 3'b010));
        tbl.push_back(mk(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 1, 0, 3'b010));
        tbl.push_back(mk(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 1, 0, 3'b010));
        tbl.push_back(mk(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b010));
        tbl.push_back(mk(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 1, 0, 3'b010));
        tbl.push_back(mk(4'h7, 4'h8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b010));
        tbl.push_back(mk(4'h6, 4'h1, 64'h1, MSB, 64'h0, MSB, 64'h1, 2'd1, MAX, 0, 0, 3'b001));
        tbl.push_back(mk(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b001));
        tbl.push_back(mk(4'h2, 4'h1, 64'h99, 64'h0, 64'h0, 64'h0, 64'h99, 2'd0, 64'h99, 1, 0, 3'b001));
        tbl.push_back(mk(4'h6, 4'h7, 64'h3, 64'h4, 64'h0, 64'h4, 64'h3, 2'd3, 64'h0, 0, 1, 3'b001));
        tbl.push_back(mk(4'hC, 4'h0, 64'h1, 64'h2, 64'h3, 64'h0, 64'h0, 2'd0, 64'h0, 0, 1, 3'b001));
        tbl.push_back(mk(4'h3, 4'h0, 64'h0, 64'h0, 64'hABCD, 64'h0, 64'hABCD, 2'd0, 64'hABCD, 0, 0, 3'b001));
        tbl.push_back(mk(4'h4, 4'h0, 64'h0, 64'h1000, 64'h20, 64'h1000, 64'h20, 2'd0, 64'h1020, 0, 0, 3'b001));
        tbl.push_back(mk(4'h5, 4'h0, 64'h0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 2'd0, 64'h1FF0, 0, 0, 3'b001));
        tbl.push_back(mk(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b001));
        tbl.push_back(mk(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 64'h200, M8, 2'd0, 64'h1F8, 0, 0, 3'b001));
        tbl.push_back(mk(4'h9, 4'h0, 64'h0, 64'h200, 64'h0, 64'h200, 64'h8, 2'd0, 64'h208, 0, 0, 3'b001));
        tbl.push_back(mk(4'h6, 4'h0, MSB, MSB, 64'h0, MSB, MSB, 2'd0, 64'h0, 0, 0, 3'b101));
        tbl.push_back(mk(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 1, 0, 3'b101));
        tbl.push_back(mk(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b101));

        in_valid = 0; in_icode = 0; in_ifun = 0; in_valA = 0; in_valB = 0; in_valC = 0;
        out_ready = 1'b1;
        cur_exp = '{default: '0};
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_cc",        64'(cc), 64'b100);
        chk("rst_out_valE",  out_valE, 64'h0);
        chk("rst_out_icode", 64'(out_icode), 64'h0);

        // Back-to-back vectors; each is accepted while the previous one drains.
        foreach (tbl[i]) begin
            apply(tbl[i]);
            #1;
            chk("alu_num1", alu_num1, tbl[i].n1);
            chk("alu_num2", alu_num2, tbl[i].n2);
            chk("alu_ctrl", 64'(alu_ctrl), 64'(tbl[i].ctrl));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("tbl_drained", 64'(sb.size()), 64'd0);

        // Reset with a result still held: it must vanish.
        out_ready = 1'b0;
        apply(mk(4'h3, 4'h0, 64'h0, 64'h0, 64'h5, 64'h0, 64'h5, 2'd0, 64'h5, 0, 0, 3'b101));
        cyc();
        in_valid = 1'b0;
        chk("midrst_full", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_valE",  out_valE, 64'h0);
        chk("midrst_cc",    64'(cc), 64'b100);
        sb.delete();
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;

        // Stall three cycles with the next instruction waiting, then drain+accept together.
        apply(mk(4'h3, 4'h0, 64'h0, 64'h0, 64'h111, 64'h0, 64'h111, 2'd0, 64'h111, 0, 0, 3'b100));
        cyc();
        out_ready = 1'b0;
        apply(mk(4'h3, 4'h0, 64'hA, 64'h0, 64'h222, 64'h0, 64'h222, 2'd0, 64'h222, 0, 0, 3'b100));
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready",  64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_valE",  out_valE, 64'h111);
            chk("stall_out_icode", 64'(out_icode), 64'h3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("nobubble_valid", 64'(out_valid), 64'd1);
            apply(mk(4'h1, 4'h0, 64'(k), 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b100));
            cyc();
        end
        chk("nobubble_last", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("stall_drained", 64'(sb.size()), 64'd0);
`ifdef EXE_PERF_CNT_EN
        chk("perf_insn",  64'(perf_insn), 64'd5);
        chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

        // Halt drains once, then the stage refuses everything until reset.
        apply(mk(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 64'h0, 0, 0, 3'b100));
        cyc();
        apply(mk(4'h3, 4'h0, 64'h0, 64'h0, 64'h333, 64'h0, 64'h333, 2'd0, 64'h333, 0, 0, 3'b100));
        #1;
        chk("halt_full_in_ready", 64'(in_ready), 64'd0);
        chk("halt_full_valid",    64'(out_valid), 64'd1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("halted_in_ready",  64'(in_ready), 64'd0);
            chk("halted_out_valid", 64'(out_valid), 64'd0);
            cyc();
        end
        chk("halt_drained", 64'(sb.size()), 64'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("post_halt_rst_in_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
